// File: rtl/merge_arb_pkg.sv
// Shared types and helpers for the merge_arb round-robin merge stage.
// Channel words are W+1 bits wide, with the valid flag in the MSB.
`ifndef MERGE_ARB_PKG_SV
`define MERGE_ARB_PKG_SV

`define MERGE_ARB_WORD_T(WIDTH) logic [(WIDTH):0]

package merge_arb_pkg;

    localparam int DEFAULT_W = 8;
    localparam int DEFAULT_N = 4;

    // Position of the valid flag inside a W-bit-payload channel word.
    function automatic int valid_bit(input int w);
        return w;
    endfunction

    // Successor of index g modulo n. The wrap is explicit, so N need not be a power of two.
    function automatic int rr_next(input int g, input int n);
        return (g + 1 >= n) ? 0 : g + 1;
    endfunction

endpackage

`endif

// File: rtl/merge_arb_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, modulo N.
module rr_pick #(
    parameter  int N  = 4,
    localparam int NW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [NW-1:0] i_ptr,
    output logic [NW-1:0] o_g,
    output logic          o_any
);

    always_comb begin
        int   idx;
        logic found;
        o_g   = i_ptr;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!found && i_req[NW'(idx)]) begin
                o_g   = NW'(idx);
                found = 1'b1;
            end
        end
        o_any = |i_req;
    end

endmodule

// File: rtl/merge_arb.sv
// N-to-1 round-robin merge into one bubble-filling output register.
// Define MERGE_ARB_SRC_EN to add the registered out_src source index port.
module merge_arb
    import merge_arb_pkg::*;
#(
    parameter  int W  = DEFAULT_W,
    parameter  int N  = DEFAULT_N,
    localparam int NW = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0][W:0] in_data,
    output logic [N-1:0]     in_stop,
    output logic [W:0]       out_data,
    input  logic             out_stop
`ifdef MERGE_ARB_SRC_EN
    ,
    output logic [NW-1:0]    out_src
`endif
);

    localparam int VB = valid_bit(W);

    typedef `MERGE_ARB_WORD_T(W) word_t;

    word_t           r_out;
    logic [NW-1:0]   r_ptr;
    logic [NW-1:0]   w_g;
    logic [N-1:0]    w_req;
    logic            w_any;
    logic            w_en;

    always_comb begin
        w_req = '0;
        for (int i = 0; i < N; i++) w_req[i] = in_data[i][VB];
    end

    rr_pick #(.N(N)) u_pick (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_g   (w_g),
        .o_any (w_any)
    );

    // The register takes a word whenever it is empty or its word is being consumed.
    assign w_en = !(r_out[VB] && out_stop);

    // Only the granted producer is released, and never while reset is held.
    always_comb begin
        in_stop = '1;
        for (int i = 0; i < N; i++) begin
            if (rst_n && w_en && w_any && (w_g == NW'(i))) in_stop[i] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= '0;
            r_ptr <= '0;
        end else if (w_en) begin
            r_out <= w_any ? word_t'(in_data[w_g]) : '0;
            if (w_any) r_ptr <= NW'(rr_next(int'(w_g), N));
        end
    end

`ifdef MERGE_ARB_SRC_EN
    logic [NW-1:0] r_src;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_src <= '0;
        end else if (w_en && w_any) begin
            r_src <= w_g;
        end
    end

    assign out_src = r_src;
`endif

    assign out_data = r_out;

endmodule
